mem_ctrler: RTL and testbench

MEM_CTRLER -- requirements
Module: mem_ctrler

---
 rtl/mem_ctrler_pkg.sv | 41 ++++
 rtl/mem_ctrler_if.sv | 49 ++++
 rtl/mem_ctrler.sv | 160 ++++++++++++++++
 tb/tb_mem_ctrler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrler_pkg.sv
// Shared configuration for the memory controller: address width, default
// cache-line size, the LSB size encoding, the IO address window, the
// cache-line type and the controller state type.
package mem_ctrler_pkg;

   localparam int ADDR_W = 32;
   localparam int LINE_BYTES_DEF = 16;

   // IO space is the window where addr[IO_HI_BIT:IO_LO_BIT] == IO_BASE_HI
   localparam int IO_HI_BIT = 17;
   localparam int IO_LO_BIT = 16;
   localparam logic [1:0] IO_BASE_HI_DEF = 2'b11;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [LINE_BYTES_DEF*8-1:0] line_t;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INST_READ,
      ST_DATA_READ,
      ST_DATA_WRITE,
      ST_DONE
   } state_e;

   // Index of the last byte of an LSB access; the unused code 3 is
   // treated as a word.
   function automatic logic [1:0] size_last_idx(input logic [1:0] size);
      case (size_e'(size))
         SIZE_B:  return 2'd0;
         SIZE_H:  return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrler_if.sv
// Bus bundle between the memory controller, its two requesters
// (instruction fetcher, load/store buffer) and the byte-wide RAM.
//   slave  : the controller side
//   master : the requester / RAM / environment side
interface mem_ctrler_if #(
   parameter int LINE_BYTES = mem_ctrler_pkg::LINE_BYTES_DEF
);
   logic                    rdy;
   logic                    io_buffer_full;

   logic                    valid_from_inst_fetcher;
   logic [31:0]             addr_from_inst_fetcher;
   logic                    ready_to_inst_fetcher;
   logic [LINE_BYTES*8-1:0] cache_line_to_inst_fetcher;

   logic                    valid_from_lsb;
   logic                    rw_from_lsb;
   logic [31:0]             addr_from_lsb;
   logic [1:0]              size_from_lsb;
   logic [31:0]             data_from_lsb;
   logic                    ready_to_lsb;
   logic [31:0]             data_to_lsb;

   logic [31:0]             mem_a;
   logic [7:0]              mem_dout;
   logic                    mem_wr;
   logic [7:0]              mem_din;

   modport slave (
      input  rdy, io_buffer_full,
      input  valid_from_inst_fetcher, addr_from_inst_fetcher,
      output ready_to_inst_fetcher, cache_line_to_inst_fetcher,
      input  valid_from_lsb, rw_from_lsb, addr_from_lsb, size_from_lsb, data_from_lsb,
      output ready_to_lsb, data_to_lsb,
      output mem_a, mem_dout, mem_wr,
      input  mem_din
   );

   modport master (
      output rdy, io_buffer_full,
      output valid_from_inst_fetcher, addr_from_inst_fetcher,
      input  ready_to_inst_fetcher, cache_line_to_inst_fetcher,
      output valid_from_lsb, rw_from_lsb, addr_from_lsb, size_from_lsb, data_from_lsb,
      input  ready_to_lsb, data_to_lsb,
      input  mem_a, mem_dout, mem_wr,
      output mem_din
   );

endinterface

// File: rtl/mem_ctrler.sv
// Memory controller: serialises instruction line fetches and LSB byte/half/
// word accesses onto a byte-wide RAM, one byte per cycle.
// Ports:
//   clk  - single clock
//   rst  - asynchronous, active-low reset
//   bus  - mem_ctrler_if.slave: requests, responses, RAM port, rdy stall,
//          io_buffer_full back-pressure
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | waiting; LSB request wins over instruction request
// ST_INST_READ  | reading LINE_BYTES bytes from the aligned line base
// ST_DATA_READ  | reading 1/2/4 bytes for the LSB
// ST_DATA_WRITE | writing 1/2/4 bytes for the LSB
// ST_DONE       | one cycle with the ready pulse high, then back to idle
module mem_ctrler
   import mem_ctrler_pkg::*;
#(
   parameter int         LINE_BYTES = LINE_BYTES_DEF,
   parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
   input  logic        clk,
   input  logic        rst,
   mem_ctrler_if.slave bus
);

   localparam int    LINE_W    = LINE_BYTES * 8;
   localparam int    CNT_W     = (LINE_BYTES > 4) ? $clog2(LINE_BYTES) : 2;
   localparam addr_t LINE_MASK = ~addr_t'(LINE_BYTES - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  last_q;
   addr_t             addr_q;
   logic [31:0]       wdata_q;
   logic [LINE_W-1:0] buf_q;
   logic [LINE_W-1:0] buf_d;
   logic [LINE_W-1:0] line_q;
   logic [31:0]       data_q;
   logic              inst_rdy_q;
   logic              lsb_rdy_q;
   logic              mem_wr_q;
   addr_t             mem_a_q;
   logic [7:0]        mem_dout_q;

   logic [CNT_W-1:0]  cnt_inc;
   addr_t             addr_next;
   logic              is_io;
   logic              lsb_ok;
   logic              last_byte;

   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign addr_next = addr_q + {{(ADDR_W-CNT_W){1'b0}}, cnt_inc};
   assign last_byte = (cnt_q == last_q);
   assign is_io     = (bus.addr_from_lsb[IO_HI_BIT:IO_LO_BIT] == IO_BASE_HI);
   // A blocked IO write must not stall the fetcher, so it simply drops out
   // of arbitration until the IO buffer drains.
   assign lsb_ok    = bus.valid_from_lsb &
                      ~(bus.rw_from_lsb & is_io & bus.io_buffer_full);

   // Assembly buffer with the byte on mem_din merged at the current index;
   // the final byte is merged on the same edge that publishes the response.
   always_comb begin
      buf_d = buf_q;
      buf_d[{cnt_q, 3'b000} +: 8] = bus.mem_din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         last_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         buf_q      <= '0;
         line_q     <= '0;
         data_q     <= '0;
         inst_rdy_q <= 1'b0;
         lsb_rdy_q  <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
      end else if (bus.rdy) begin
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               buf_q <= '0;
               if (lsb_ok) begin
                  addr_q  <= bus.addr_from_lsb;
                  mem_a_q <= bus.addr_from_lsb;
                  last_q  <= CNT_W'(size_last_idx(bus.size_from_lsb));
                  wdata_q <= bus.data_from_lsb;
                  if (bus.rw_from_lsb) begin
                     state_q    <= ST_DATA_WRITE;
                     mem_wr_q   <= 1'b1;
                     mem_dout_q <= bus.data_from_lsb[7:0];
                  end else begin
                     state_q <= ST_DATA_READ;
                  end
               end else if (bus.valid_from_inst_fetcher) begin
                  state_q <= ST_INST_READ;
                  addr_q  <= bus.addr_from_inst_fetcher & LINE_MASK;
                  mem_a_q <= bus.addr_from_inst_fetcher & LINE_MASK;
                  last_q  <= CNT_W'(LINE_BYTES - 1);
               end
            end

            ST_INST_READ, ST_DATA_READ: begin
               buf_q <= buf_d;
               if (last_byte) begin
                  if (state_q == ST_INST_READ) begin
                     line_q     <= buf_d;
                     inst_rdy_q <= 1'b1;
                  end else begin
                     // buffer was cleared on acceptance, so short reads
                     // come out zero-extended
                     data_q    <= buf_d[31:0];
                     lsb_rdy_q <= 1'b1;
                  end
                  state_q <= ST_DONE;
               end else begin
                  cnt_q   <= cnt_inc;
                  mem_a_q <= addr_next;
               end
            end

            ST_DATA_WRITE: begin
               if (last_byte) begin
                  mem_wr_q  <= 1'b0;
                  lsb_rdy_q <= 1'b1;
                  state_q   <= ST_DONE;
               end else begin
                  cnt_q      <= cnt_inc;
                  mem_a_q    <= addr_next;
                  mem_dout_q <= wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
               end
            end

            ST_DONE: begin
               inst_rdy_q <= 1'b0;
               lsb_rdy_q  <= 1'b0;
               cnt_q      <= '0;
               state_q    <= ST_IDLE;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.ready_to_inst_fetcher      = inst_rdy_q;
   assign bus.cache_line_to_inst_fetcher = line_q;
   assign bus.ready_to_lsb               = lsb_rdy_q;
   assign bus.data_to_lsb                = data_q;
   assign bus.mem_a                      = mem_a_q;
   assign bus.mem_dout                   = mem_dout_q;
   // a stalled cycle must not repeat a write strobe into the RAM
   assign bus.mem_wr                     = mem_wr_q & bus.rdy;

endmodule

// File: tb/tb_mem_ctrler.sv
module tb_mem_ctrler;
   import mem_ctrler_pkg::*;

   localparam int LB = LINE_BYTES_DEF;

   logic  clk = 1'b0;
   logic  rst = 1'b0;
   logic  load_ram = 1'b0;
   int    checks = 0;
   int    errors = 0;
   int    wr_cycles = 0;
   logic [7:0] ram   [0:65535];
   logic [7:0] model [0:65535];
   line_t       last_line;
   logic [31:0] last_rd;

   mem_ctrler_if #(.LINE_BYTES(LB)) bus ();

   mem_ctrler #(.LINE_BYTES(LB), .IO_BASE_HI(2'b11)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // byte RAM: the byte for the address presented in a cycle is on mem_din
   // by the edge that closes that cycle; writes land on that edge
   assign bus.mem_din = ram[bus.mem_a[15:0]];
   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < 65536; i++) ram[i] <= model[i];
      end else if (bus.mem_wr) begin
         ram[bus.mem_a[15:0]] <= bus.mem_dout;
         wr_cycles <= wr_cycles + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // entered just after a rising edge numbered k; returns at the falling
   // edge where the chosen ready is high, or after the budget runs out
   task automatic wait_rdy(input bit want_inst, input int budget, inout int k);
      bit hit;
      hit = 1'b0;
      while (!hit && k <= budget) begin
         @(negedge clk);
         hit = want_inst ? bus.ready_to_inst_fetcher : bus.ready_to_lsb;
         if (!hit) begin
            @(posedge clk);
            k++;
         end
      end
   endtask

   task automatic inst_fetch(input logic [31:0] a, input int stall_at, input int stall_len,
                             input string tag);
      logic [31:0] base;
      line_t       exp_line;
      int          k, bad, w0;
      bit          hit;
      base = a & ~32'(LB - 1);
      for (int i = 0; i < LB; i++) exp_line[i*8 +: 8] = model[16'(base + 32'(i))];
      w0 = wr_cycles; bad = 0; k = 0; hit = 1'b0;
      bus.valid_from_inst_fetcher = 1'b1;
      bus.addr_from_inst_fetcher  = a;
      @(posedge clk);
      #1 bus.addr_from_inst_fetcher = ~a;
      while (!hit && k <= 60) begin
         if (stall_len > 0 && k == stall_at) #1 bus.rdy = 1'b0;
         if (stall_len > 0 && k == stall_at + stall_len) #1 bus.rdy = 1'b1;
         @(negedge clk);
         if (stall_len == 0 && k < LB && bus.mem_a !== base + 32'(k)) bad++;
         hit = bus.ready_to_inst_fetcher;
         if (!hit) begin
            @(posedge clk);
            k++;
         end
      end
      bus.valid_from_inst_fetcher = 1'b0;
      check({tag, "_lat"}, k, LB + stall_len);
      check({tag, "_line"}, bus.cache_line_to_inst_fetcher, exp_line);
      check({tag, "_addr_seq"}, bad, 0);
      check({tag, "_no_wr"}, wr_cycles - w0, 0);
      check({tag, "_lsb_hold"}, bus.data_to_lsb, last_rd);
      last_line = exp_line;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_pulse1"}, bus.ready_to_inst_fetcher, 1'b0);
   endtask

   task automatic lsb_access(input logic rw, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] d, input string tag);
      int          n, k, bad, w0;
      bit          hit;
      logic [31:0] exp_d;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      exp_d = '0;
      for (int i = 0; i < n; i++) begin
         exp_d[i*8 +: 8] = model[16'(a + 32'(i))];
         if (rw) model[16'(a + 32'(i))] = d[i*8 +: 8];
      end
      w0 = wr_cycles; bad = 0; k = 0; hit = 1'b0;
      bus.valid_from_lsb = 1'b1;
      bus.rw_from_lsb    = rw;
      bus.addr_from_lsb  = a;
      bus.size_from_lsb  = sz;
      bus.data_from_lsb  = d;
      @(posedge clk);
      #1;
      bus.rw_from_lsb   = ~rw;
      bus.addr_from_lsb = ~a;
      bus.size_from_lsb = ~sz;
      bus.data_from_lsb = ~d;
      while (!hit && k <= 40) begin
         @(negedge clk);
         if (k < n) begin
            if (bus.mem_a !== a + 32'(k)) bad++;
            if (bus.mem_wr !== rw) bad++;
            if (rw && bus.mem_dout !== d[k*8 +: 8]) bad++;
         end
         hit = bus.ready_to_lsb;
         if (!hit) begin
            @(posedge clk);
            k++;
         end
      end
      bus.valid_from_lsb = 1'b0;
      check({tag, "_lat"}, k, n);
      check({tag, "_bus_seq"}, bad, 0);
      check({tag, "_wr_low_at_ready"}, bus.mem_wr, 1'b0);
      check({tag, "_wr_count"}, wr_cycles - w0, rw ? n : 0);
      if (!rw) begin
         check({tag, "_data"}, bus.data_to_lsb, exp_d);
         last_rd = exp_d;
      end else begin
         check({tag, "_data_hold"}, bus.data_to_lsb, last_rd);
      end
      check({tag, "_line_hold"}, bus.cache_line_to_inst_fetcher, last_line);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_pulse1"}, bus.ready_to_lsb, 1'b0);
   endtask

   initial begin
      int    k, w0, pulses;
      line_t seq_line;

      bus.rdy = 1'b1;
      bus.io_buffer_full = 1'b0;
      bus.valid_from_inst_fetcher = 1'b0;
      bus.addr_from_inst_fetcher  = '0;
      bus.valid_from_lsb = 1'b0;
      bus.rw_from_lsb    = 1'b0;
      bus.addr_from_lsb  = '0;
      bus.size_from_lsb  = '0;
      bus.data_from_lsb  = '0;
      last_line = '0;
      last_rd   = '0;

      for (int i = 0; i < 65536; i++) model[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) model[16'h0100 + i] = 8'(i);
      model[16'h0200] = 8'h78;
      model[16'h0201] = 8'h56;
      model[16'h0202] = 8'h34;
      model[16'h0203] = 8'h12;
      for (int i = 0; i < LB; i++) seq_line[i*8 +: 8] = 8'(i);
      load_ram = 1'b1;
      @(posedge clk);
      #1 load_ram = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      check("rst_ready_inst", bus.ready_to_inst_fetcher, 1'b0);
      check("rst_ready_lsb", bus.ready_to_lsb, 1'b0);
      check("rst_mem_wr", bus.mem_wr, 1'b0);
      check("rst_mem_a", bus.mem_a, 32'h0);
      check("rst_line", bus.cache_line_to_inst_fetcher, '0);

      // line fetch from an unaligned address
      inst_fetch(32'h0000_010C, 0, 0, "inst");
      check("inst_line_const", bus.cache_line_to_inst_fetcher, seq_line);

      // simultaneous requests: LSB first, then the line
      bus.valid_from_inst_fetcher = 1'b1;
      bus.addr_from_inst_fetcher  = 32'h0000_0104;
      bus.valid_from_lsb = 1'b1;
      bus.rw_from_lsb    = 1'b0;
      bus.addr_from_lsb  = 32'h0000_0200;
      bus.size_from_lsb  = 2'd2;
      @(posedge clk);
      k = 0;
      wait_rdy(1'b0, 30, k);
      check("prio_lsb_lat", k, 4);
      check("prio_lsb_data", bus.data_to_lsb, 32'h1234_5678);
      check("prio_inst_waits", bus.ready_to_inst_fetcher, 1'b0);
      last_rd = 32'h1234_5678;
      bus.valid_from_lsb = 1'b0;
      @(posedge clk);
      k++;
      wait_rdy(1'b1, 60, k);
      check("prio_inst_lat", k, 22);
      check("prio_inst_line", bus.cache_line_to_inst_fetcher, seq_line);
      last_line = seq_line;
      bus.valid_from_inst_fetcher = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // word store and read-back
      lsb_access(1'b1, 32'h0000_0300, 2'd2, 32'hDEAD_BEEF, "store");
      lsb_access(1'b0, 32'h0000_0300, 2'd2, 32'h0, "store_rb");
      check("store_rb_const", bus.data_to_lsb, 32'hDEAD_BEEF);

      // blocked IO write while a line fetch is pending
      model[16'h0000] = 8'hA5;
      bus.io_buffer_full = 1'b1;
      bus.valid_from_lsb = 1'b1;
      bus.rw_from_lsb    = 1'b1;
      bus.addr_from_lsb  = 32'h0003_0000;
      bus.size_from_lsb  = 2'd0;
      bus.data_from_lsb  = 32'h0000_00A5;
      bus.valid_from_inst_fetcher = 1'b1;
      bus.addr_from_inst_fetcher  = 32'h0000_0100;
      w0 = wr_cycles;
      @(posedge clk);
      k = 0;
      repeat (4) begin
         @(posedge clk);
         k++;
      end
      #1 bus.io_buffer_full = 1'b0;
      wait_rdy(1'b1, 60, k);
      check("io_inst_lat", k, 16);
      check("io_inst_line", bus.cache_line_to_inst_fetcher, seq_line);
      check("io_no_early_wr", wr_cycles - w0, 0);
      bus.valid_from_inst_fetcher = 1'b0;
      @(posedge clk);
      k++;
      wait_rdy(1'b0, 60, k);
      check("io_wr_lat", k, 19);
      check("io_wr_count", wr_cycles - w0, 1);
      bus.valid_from_lsb = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // IO write alone stays parked while the buffer is full
      model[16'hABCD] = 8'h3C;
      bus.io_buffer_full = 1'b1;
      bus.valid_from_lsb = 1'b1;
      bus.rw_from_lsb    = 1'b1;
      bus.addr_from_lsb  = 32'h0003_ABCD;
      bus.size_from_lsb  = 2'd0;
      bus.data_from_lsb  = 32'h0000_003C;
      w0 = wr_cycles;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("io_block_ready", bus.ready_to_lsb, 1'b0);
      check("io_block_wr", wr_cycles - w0, 0);
      bus.io_buffer_full = 1'b0;
      @(posedge clk);
      k = 0;
      wait_rdy(1'b0, 20, k);
      check("io_unblock_lat", k, 1);
      check("io_unblock_wr", wr_cycles - w0, 1);
      bus.valid_from_lsb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lsb_access(1'b0, 32'h0000_0000, 2'd0, 32'h0, "io_rb0");
      lsb_access(1'b0, 32'h0000_ABCD, 2'd0, 32'h0, "io_rb1");

      // rdy low for three cycles in the middle of a line
      inst_fetch(32'h0000_0100, 5, 3, "rdy_stall");

      // reset in the middle of a line fetch
      bus.valid_from_inst_fetcher = 1'b1;
      bus.addr_from_inst_fetcher  = 32'h0000_0100;
      repeat (6) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("midrst_ready_inst", bus.ready_to_inst_fetcher, 1'b0);
      check("midrst_ready_lsb", bus.ready_to_lsb, 1'b0);
      check("midrst_mem_wr", bus.mem_wr, 1'b0);
      check("midrst_mem_a", bus.mem_a, 32'h0);
      check("midrst_mem_dout", bus.mem_dout, 8'h0);
      check("midrst_data", bus.data_to_lsb, 32'h0);
      check("midrst_line", bus.cache_line_to_inst_fetcher, '0);
      bus.valid_from_inst_fetcher = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      repeat (24) begin
         @(negedge clk);
         if (bus.ready_to_inst_fetcher || bus.ready_to_lsb) pulses++;
      end
      check("midrst_no_pulse", pulses, 0);
      last_line = '0;
      last_rd   = '0;

      // 32-bit address wrap
      lsb_access(1'b0, 32'hFFFF_FFFF, 2'd0, 32'h0, "wrap_b");
      lsb_access(1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0, "wrap_h");

      // random mix against the model memory
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 2) == 0)
            inst_fetch($urandom, 0, 0, "rnd_inst");
         else
            lsb_access(1'($urandom), $urandom, 2'($urandom_range(0, 2)), $urandom, "rnd_lsb");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
